// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter that shares one WIDTH-bit datapath into a
// single registered output stage, with a per-grant burst limit against starvation.
module mux_rr_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t             r_state;
    logic               r_last_a;
    logic [7:0]         r_burst_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_sel;
    logic               r_busy;

    logic               w_slot_free;
    logic               w_accept_a;
    logic               w_accept_b;
    logic               w_burst_done;

    // Readies depend only on registered state and out_ready, never on the valids.
    assign w_slot_free  = !r_out_valid || out_ready;
    assign a_ready      = (r_state == GRANT_A) && w_slot_free;
    assign b_ready      = (r_state == GRANT_B) && w_slot_free;
    assign w_accept_a   = a_valid && a_ready;
    assign w_accept_b   = b_valid && b_ready;
    assign w_burst_done = (r_burst_cnt + 8'd1) == BURST_LIMIT;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel_o     = r_sel;
    assign busy_o    = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_a    <= 1'b0;
            r_burst_cnt <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept_a || w_accept_b) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_accept_a ? a_data : b_data;
            end else begin
                r_out_valid <= r_out_valid && !out_ready;
            end

            case (r_state)
                IDLE: begin
                    r_burst_cnt <= 8'd0;
                    // On a tie the side that was not served last wins.
                    if (a_valid && (!b_valid || !r_last_a)) begin
                        r_state <= GRANT_A;
                        r_sel   <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (b_valid) begin
                        r_state <= GRANT_B;
                        r_sel   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                GRANT_A: begin
                    if (!a_valid || (w_accept_a && w_burst_done && b_valid)) begin
                        r_last_a    <= 1'b1;
                        r_burst_cnt <= 8'd0;
                        r_sel       <= 1'b0;
                        if (b_valid) begin
                            r_state <= GRANT_B;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_accept_a) begin
                        r_burst_cnt <= w_burst_done ? 8'd0 : r_burst_cnt + 8'd1;
                    end
                end
                GRANT_B: begin
                    if (!b_valid || (w_accept_b && w_burst_done && a_valid)) begin
                        r_last_a    <= 1'b0;
                        r_burst_cnt <= 8'd0;
                        if (a_valid) begin
                            r_state <= GRANT_A;
                            r_sel   <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_sel   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_accept_b) begin
                        r_burst_cnt <= w_burst_done ? 8'd0 : r_burst_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sel   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, directed streaming and
// contention sequences, a MAX_BURST=1 instance, and a randomized reference model.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

    localparam int W  = 16;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         aValid, bValid, outReady;
    logic [W-1:0] aData, bData;
    logic         aReady, bReady, outValid, selO, busyO;
    logic [W-1:0] outData;

    logic         a1Valid, b1Valid, out1Ready;
    logic [W-1:0] a1Data, b1Data;
    logic         a1Ready, b1Ready, out1Valid, sel1O, busy1O;
    logic [W-1:0] out1Data;

    int checks   = 0;
    int failures = 0;
    int cycleNum = 0;
    logic [W-1:0] gotQ[$];
    int           outCycle[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(aValid), .a_data(aData), .a_ready(aReady),
        .b_valid(bValid), .b_data(bData), .b_ready(bReady),
        .out_valid(outValid), .out_data(outData), .out_ready(outReady),
        .sel_o(selO), .busy_o(busyO)
    );

    mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a1Valid), .a_data(a1Data), .a_ready(a1Ready),
        .b_valid(b1Valid), .b_data(b1Data), .b_ready(b1Ready),
        .out_valid(out1Valid), .out_data(out1Data), .out_ready(out1Ready),
        .sel_o(sel1O), .busy_o(busy1O)
    );

    typedef struct {
        logic         aV;
        logic [W-1:0] aD;
        logic         bV;
        logic [W-1:0] bD;
        logic         oR;
        logic [4:0]   expFlags;
        logic [W-1:0] expData;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and samples just after.
    task automatic applyStimulus(input logic av, input logic [W-1:0] ad,
                                 input logic bv, input logic [W-1:0] bd, input logic orr);
        @(negedge clk);
        aValid = av; aData = ad; bValid = bv; bData = bd; outReady = orr;
        #1;
        if (outValid && outReady) begin
            gotQ.push_back(outData);
            outCycle.push_back(cycleNum);
        end
        cycleNum++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        aValid = 0; bValid = 0; aData = 0; bData = 0; outReady = 0;
        a1Valid = 0; b1Valid = 0; a1Data = 0; b1Data = 0; out1Ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        gotQ.delete();
        outCycle.delete();
    endtask

    task automatic checkSeq(input string name, input logic [W-1:0] act[$], input logic [W-1:0] exp[$]);
        int bad = 0;
        int firstBad = -1;
        if (act.size() < exp.size()) bad = 1;
        else
            for (int i = 0; i < exp.size(); i++)
                if (act[i] !== exp[i] && firstBad < 0) begin bad = 1; firstBad = i; end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL %s actual_len=%0d required_len=%0d first_bad_idx=%0d actual=%0h required=%0h",
                     name, act.size(), exp.size(), firstBad,
                     (firstBad >= 0) ? act[firstBad] : 16'h0, (firstBad >= 0) ? exp[firstBad] : 16'h0);
        end
    endtask

    task automatic checkBackToBack(input string name, input int count);
        int gaps = 0;
        if (outCycle.size() < count) gaps = count;
        else
            for (int i = 1; i < count; i++)
                if (outCycle[i] != outCycle[i-1] + 1) gaps++;
        checkOutput(name, gaps, 0);
    endtask

    // Both sides stream continuously; optional out_ready stall window.
    task automatic runContention(input int stallFrom, input int stallLen, input string tag);
        int aIdx = 0;
        int bIdx = 0;
        int stallBad = 0;
        logic [W-1:0] held = '0;
        logic [W-1:0] expQ[$];
        for (int cyc = 0; cyc < 80 && gotQ.size() < 12; cyc++) begin
            logic stall;
            stall = (cyc >= stallFrom) && (cyc < stallFrom + stallLen);
            applyStimulus(1'b1, 16'hA000 + 16'(aIdx), 1'b1, 16'hB000 + 16'(bIdx), !stall);
            if (stall) begin
                if (cyc == stallFrom) held = outData;
                if (!outValid || outData !== held || aReady || bReady) stallBad++;
            end
            if (aReady) aIdx++;
            if (bReady) bIdx++;
        end
        for (int i = 0; i < 4; i++)  expQ.push_back(16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++)  expQ.push_back(16'hB000 + 16'(i));
        for (int i = 4; i < 8; i++)  expQ.push_back(16'hA000 + 16'(i));
        checkSeq({tag, "_order"}, gotQ, expQ);
        if (stallLen > 0) checkOutput({tag, "_stall_hold"}, stallBad, 0);
        else checkBackToBack({tag, "_no_bubbles"}, 12);
    endtask

    initial begin
        logic [31:0] act;
        rst_n = 1'b0;
        aValid = 0; bValid = 0; aData = 0; bData = 0; outReady = 0;
        a1Valid = 0; b1Valid = 0; a1Data = 0; b1Data = 0; out1Ready = 0;

        vecs[0]  = '{1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1, 5'b00000, 16'h0000};
        vecs[1]  = '{1'b1, 16'h0011, 1'b1, 16'h0022, 1'b1, 5'b10011, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0012, 1'b1, 16'h0022, 1'b1, 5'b10111, 16'h0011};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0022, 1'b1, 5'b10111, 16'h0012};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0022, 1'b0, 5'b01001, 16'h0012};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0023, 1'b0, 5'b00101, 16'h0022};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0023, 1'b1, 5'b01101, 16'h0022};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 5'b01101, 16'h0023};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 5'b00000, 16'h0023};
        vecs[9]  = '{1'b1, 16'h0031, 1'b1, 16'h0041, 1'b1, 5'b00000, 16'h0023};
        vecs[10] = '{1'b1, 16'h0031, 1'b1, 16'h0041, 1'b1, 5'b10011, 16'h0023};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_state", {11'd0, aReady, bReady, outValid, selO, busyO, outData}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].aV, vecs[i].aD, vecs[i].bV, vecs[i].bD, vecs[i].oR);
            checkOutput($sformatf("vec%0d", i), {11'd0, aReady, bReady, outValid, selO, busyO, outData},
                        {11'd0, vecs[i].expFlags, vecs[i].expData});
        end

        // Reset mid-stream while a beat sits in the output register.
        @(negedge clk);
        checkOutput("pre_reset_out_valid", {31'd0, outValid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {11'd0, aReady, bReady, outValid, selO, busyO, outData}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0051, 1'b1, 16'h0061, 1'b1);
        applyStimulus(1'b1, 16'h0051, 1'b1, 16'h0061, 1'b1);
        checkOutput("first_grant_a", {30'd0, selO, aReady}, 32'd3);

        // Single requester streaming 1..10.
        doReset();
        begin
            int n = 1;
            int firstValidAt = -1;
            int leftA = 0;
            logic [W-1:0] expQ[$];
            for (int cyc = 0; cyc < 100 && n <= 10; cyc++) begin
                applyStimulus(1'b1, 16'(n), 1'b0, 16'h0, 1'b1);
                if (outValid && firstValidAt < 0) firstValidAt = cyc;
                if (busyO && !selO) leftA++;
                if (aReady) n++;
            end
            repeat (3) applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
            for (int i = 1; i <= 10; i++) expQ.push_back(16'(i));
            checkOutput("stream_latency", firstValidAt, 2);
            checkOutput("stream_grant_stays_a", leftA, 0);
            checkSeq("stream_order", gotQ, expQ);
            checkBackToBack("stream_no_bubbles", 10);
            checkOutput("stream_idle_busy", {31'd0, busyO}, 32'd0);
        end

        doReset();
        runContention(1000, 0, "contention");
        doReset();
        runContention(4, 5, "backpressure");

        // MAX_BURST=1 instance: strict interleave, then idle.
        doReset();
        begin
            int i1 = 0;
            int j1 = 0;
            logic [W-1:0] got1[$];
            logic [W-1:0] expQ[$];
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                a1Valid = 1; a1Data = 16'hA000 + 16'(i1);
                b1Valid = 1; b1Data = 16'hB000 + 16'(j1);
                out1Ready = 1;
                #1;
                if (out1Valid) got1.push_back(out1Data);
                if (a1Ready) i1++;
                if (b1Ready) j1++;
            end
            for (int i = 0; i < 5; i++) begin
                expQ.push_back(16'hA000 + 16'(i));
                expQ.push_back(16'hB000 + 16'(i));
            end
            checkSeq("burst1_interleave", got1, expQ);
            repeat (3) begin
                @(negedge clk);
                a1Valid = 0; b1Valid = 0;
            end
            #1;
            checkOutput("burst1_idle", {30'd0, busy1O, out1Valid}, 32'd0);
        end

        // Randomized run against a behavioural model of the arbitration rules.
        doReset();
        begin
            int   mGrant = 0;
            bit   mLastA = 0;
            int   mRun = 0;
            bit   mOutValid = 0;
            logic [W-1:0] mOutData = '0;
            bit   prevAccA = 0;
            bit   prevAccB = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                bit slotFree, expA, expB, accA, accB, mine, other;
                @(negedge clk);
                if (!aValid || prevAccA) begin aValid = ($urandom_range(0, 3) != 0); aData = 16'($urandom); end
                if (!bValid || prevAccB) begin bValid = ($urandom_range(0, 3) != 0); bData = 16'($urandom); end
                outReady = ($urandom_range(0, 3) != 0);
                #1;
                slotFree = !mOutValid || outReady;
                expA = (mGrant == 1) && slotFree;
                expB = (mGrant == 2) && slotFree;
                act = {11'd0, aReady, bReady, outValid, selO, busyO, outData};
                checkOutput($sformatf("rand_cyc%0d", cyc), act,
                            {11'd0, expA, expB, mOutValid, mGrant == 1, mGrant != 0, mOutData});
                accA = aValid && expA;
                accB = bValid && expB;
                if (accA || accB) begin
                    mOutValid = 1;
                    mOutData = accA ? aData : bData;
                end else if (outReady) mOutValid = 0;
                if (mGrant == 0) begin
                    mRun = 0;
                    if (aValid && bValid) mGrant = mLastA ? 2 : 1;
                    else if (aValid) mGrant = 1;
                    else if (bValid) mGrant = 2;
                end else begin
                    mine  = (mGrant == 1) ? aValid : bValid;
                    other = (mGrant == 1) ? bValid : aValid;
                    if (!mine || ((accA || accB) && mRun + 1 == MB && other)) begin
                        mLastA = (mGrant == 1);
                        mGrant = other ? 3 - mGrant : 0;
                        mRun = 0;
                    end else if (accA || accB) begin
                        mRun = (mRun + 1 == MB) ? 0 : mRun + 1;
                    end
                end
                prevAccA = accA;
                prevAccB = accB;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
